// File: rtl/pkg_soc_interconnect.sv
// Shared SoC interconnect types: the address-map rule and the crossbar's error read data.
package pkg_soc_interconnect;

  typedef struct packed {
    logic [31:0] idx;
    logic [31:0] start_addr;
    logic [31:0] end_addr;
  } addr_map_rule_t;

  localparam logic [31:0] XBAR_ERR_RDATA = 32'hBADACCE5;

endpackage

// File: rtl/tcdm_rr_arb.sv
// Round-robin arbiter: picks the first requester at or after the pointer;
// the pointer advances past the winner only when the caller reports a handshake.
module tcdm_rr_arb #(
  parameter int unsigned NR_REQ = 2,
  parameter int unsigned IW     = (NR_REQ > 1) ? $clog2(NR_REQ) : 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [NR_REQ-1:0] req_i,
  input  logic              hs_i,
  output logic [NR_REQ-1:0] gnt_o,
  output logic [IW-1:0]     idx_o
);

  logic [IW-1:0] ptr_q, ptr_d;
  logic          found;

  always_comb begin
    int unsigned pos;
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < NR_REQ; k++) begin
      pos = int'(ptr_q) + k;
      if (pos >= NR_REQ) pos = pos - NR_REQ;
      if (!found && req_i[pos]) begin
        found = 1'b1;
        idx_o = IW'(pos);
      end
    end
    if (found) gnt_o[idx_o] = 1'b1;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (hs_i && found) begin
      ptr_d = (int'(idx_o) == NR_REQ - 1) ? '0 : idx_o + IW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end

endmodule

// File: rtl/soc_tcdm_xbar.sv
// N-master x M-slave TCDM crossbar: rule-table decode, per-slave round-robin,
// one-cycle response routing and an internal error responder for unmapped accesses.
module soc_tcdm_xbar
  import pkg_soc_interconnect::*;
#(
  parameter int unsigned           NR_MASTERS  = 9,
  parameter int unsigned           NR_SLAVES   = 3,
  parameter int unsigned           NR_RULES    = 3,
  parameter int unsigned           ADDR_WIDTH  = 32,
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter bit                    DEFAULT_EN  = 1'b0,
  parameter int unsigned           DEFAULT_IDX = 0,
  parameter logic [DATA_WIDTH-1:0] ERR_RDATA   = XBAR_ERR_RDATA
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  addr_map_rule_t [NR_RULES-1:0]      addr_map_i,
  input  logic [NR_MASTERS-1:0]              m_req_i,
  input  logic [NR_MASTERS*ADDR_WIDTH-1:0]   m_add_i,
  input  logic [NR_MASTERS-1:0]              m_wen_i,
  input  logic [NR_MASTERS*DATA_WIDTH-1:0]   m_wdata_i,
  input  logic [NR_MASTERS*DATA_WIDTH/8-1:0] m_be_i,
  output logic [NR_MASTERS-1:0]              m_gnt_o,
  output logic [NR_MASTERS-1:0]              m_r_valid_o,
  output logic [NR_MASTERS*DATA_WIDTH-1:0]   m_r_rdata_o,
  output logic [NR_MASTERS-1:0]              m_r_opc_o,
  output logic [NR_SLAVES-1:0]               s_req_o,
  output logic [NR_SLAVES*ADDR_WIDTH-1:0]    s_add_o,
  output logic [NR_SLAVES-1:0]               s_wen_o,
  output logic [NR_SLAVES*DATA_WIDTH-1:0]    s_wdata_o,
  output logic [NR_SLAVES*DATA_WIDTH/8-1:0]  s_be_o,
  input  logic [NR_SLAVES-1:0]               s_gnt_i,
  input  logic [NR_SLAVES-1:0]               s_r_valid_i,
  input  logic [NR_SLAVES*DATA_WIDTH-1:0]    s_r_rdata_i,
  input  logic [NR_SLAVES-1:0]               s_r_opc_i
);

  localparam int unsigned MW = (NR_MASTERS > 1) ? $clog2(NR_MASTERS) : 1;
  localparam int unsigned SW = (NR_SLAVES > 1) ? $clog2(NR_SLAVES) : 1;
  localparam int unsigned BW = DATA_WIDTH / 8;

  logic [SW-1:0]         tgt [NR_MASTERS];
  logic [NR_MASTERS-1:0] err_req;
  logic [NR_MASTERS-1:0] slv_gnt [NR_SLAVES];
  logic [MW-1:0]         slv_idx [NR_SLAVES];
  logic [NR_MASTERS-1:0] err_gnt;
  logic [MW-1:0]         err_idx;

  logic [NR_SLAVES-1:0]  rsp_vld_q, rsp_vld_d;
  logic [MW-1:0]         rsp_mst_q [NR_SLAVES];
  logic                  err_vld_q, err_vld_d;
  logic                  err_rd_q;
  logic [MW-1:0]         err_mst_q;

  // Lowest-index matching rule decides; a rule pointing past the last slave counts as unmapped.
  always_comb begin
    logic hit, mapped;
    for (int unsigned i = 0; i < NR_MASTERS; i++) begin
      hit    = 1'b0;
      mapped = 1'b0;
      tgt[i] = SW'(DEFAULT_IDX);
      for (int unsigned r = 0; r < NR_RULES; r++) begin
        if (!hit &&
            m_add_i[i*ADDR_WIDTH +: ADDR_WIDTH] >= ADDR_WIDTH'(addr_map_i[r].start_addr) &&
            m_add_i[i*ADDR_WIDTH +: ADDR_WIDTH] <  ADDR_WIDTH'(addr_map_i[r].end_addr)) begin
          hit = 1'b1;
          if (addr_map_i[r].idx < NR_SLAVES) begin
            mapped = 1'b1;
            tgt[i] = addr_map_i[r].idx[SW-1:0];
          end
        end
      end
      err_req[i] = m_req_i[i] & ~mapped & ~DEFAULT_EN;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NR_SLAVES; gi++) begin : g_slv
      logic [NR_MASTERS-1:0] req;
      always_comb begin
        for (int unsigned i = 0; i < NR_MASTERS; i++) begin
          req[i] = m_req_i[i] & ~err_req[i] & (tgt[i] == SW'(gi));
        end
      end

      tcdm_rr_arb #(.NR_REQ(NR_MASTERS), .IW(MW)) u_arb (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .req_i  (req),
        .hs_i   (rsp_vld_d[gi]),
        .gnt_o  (slv_gnt[gi]),
        .idx_o  (slv_idx[gi])
      );

      assign s_req_o[gi]                          = |req;
      assign rsp_vld_d[gi]                        = s_req_o[gi] & s_gnt_i[gi];
      assign s_add_o[gi*ADDR_WIDTH +: ADDR_WIDTH] = m_add_i[slv_idx[gi]*ADDR_WIDTH +: ADDR_WIDTH];
      assign s_wen_o[gi]                          = m_wen_i[slv_idx[gi]];
      assign s_wdata_o[gi*DATA_WIDTH +: DATA_WIDTH] = m_wdata_i[slv_idx[gi]*DATA_WIDTH +: DATA_WIDTH];
      assign s_be_o[gi*BW +: BW]                  = m_be_i[slv_idx[gi]*BW +: BW];
    end
  endgenerate

  // The error responder always accepts, so its handshake is simply "someone is unmapped".
  assign err_vld_d = |err_req;

  tcdm_rr_arb #(.NR_REQ(NR_MASTERS), .IW(MW)) u_err_arb (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .req_i  (err_req),
    .hs_i   (err_vld_d),
    .gnt_o  (err_gnt),
    .idx_o  (err_idx)
  );

  always_comb begin
    m_gnt_o = err_gnt;
    for (int unsigned j = 0; j < NR_SLAVES; j++) begin
      m_gnt_o = m_gnt_o | (slv_gnt[j] & {NR_MASTERS{s_gnt_i[j]}});
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rsp_vld_q <= '0;
      err_vld_q <= 1'b0;
      err_rd_q  <= 1'b0;
      err_mst_q <= '0;
      for (int unsigned j = 0; j < NR_SLAVES; j++) rsp_mst_q[j] <= '0;
    end else begin
      rsp_vld_q <= rsp_vld_d;
      err_vld_q <= err_vld_d;
      err_rd_q  <= m_wen_i[err_idx];
      err_mst_q <= err_idx;
      for (int unsigned j = 0; j < NR_SLAVES; j++) rsp_mst_q[j] <= slv_idx[j];
    end
  end

  // Slave responses with no tracked handshake never reach a master.
  always_comb begin
    m_r_valid_o = '0;
    m_r_opc_o   = '0;
    m_r_rdata_o = '0;
    for (int unsigned j = 0; j < NR_SLAVES; j++) begin
      if (rsp_vld_q[j]) begin
        m_r_valid_o[rsp_mst_q[j]] = s_r_valid_i[j];
        m_r_opc_o[rsp_mst_q[j]]   = s_r_opc_i[j];
        m_r_rdata_o[rsp_mst_q[j]*DATA_WIDTH +: DATA_WIDTH] = s_r_rdata_i[j*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    if (err_vld_q) begin
      m_r_valid_o[err_mst_q] = 1'b1;
      m_r_opc_o[err_mst_q]   = 1'b1;
      m_r_rdata_o[err_mst_q*DATA_WIDTH +: DATA_WIDTH] = err_rd_q ? ERR_RDATA : '0;
    end
  end

endmodule

// File: tb/tb_soc_tcdm_xbar.sv
// Directed bench for soc_tcdm_xbar: error-responder instance plus a default-slave instance.
module tb_soc_tcdm_xbar;
  import pkg_soc_interconnect::*;

  localparam int NM = 9;
  localparam int NS = 3;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  addr_map_rule_t [2:0] amap;
  logic [NM-1:0]      m_req, m_wen;
  logic [NM*AW-1:0]   m_add;
  logic [NM*DW-1:0]   m_wdata;
  logic [NM*4-1:0]    m_be;
  logic [NS-1:0]      s_gnt, s_rvld, s_ropc;
  logic [NS*DW-1:0]   s_rdata;

  logic [NM-1:0]      m_gnt, m_rvld, m_ropc;
  logic [NM*DW-1:0]   m_rdata;
  logic [NS-1:0]      s_req, s_wen;
  logic [NS*AW-1:0]   s_add;
  logic [NS*DW-1:0]   s_wdata;
  logic [NS*4-1:0]    s_be;

  logic [NM-1:0]      b_m_gnt, b_m_rvld, b_m_ropc;
  logic [NM*DW-1:0]   b_m_rdata;
  logic [NS-1:0]      b_s_req, b_s_wen;
  logic [NS*AW-1:0]   b_s_add;
  logic [NS*DW-1:0]   b_s_wdata;
  logic [NS*4-1:0]    b_s_be;

  soc_tcdm_xbar #(.NR_MASTERS(NM), .NR_SLAVES(NS), .NR_RULES(3), .DEFAULT_EN(1'b0)) dut (
    .clk_i(clk), .rst_ni(rst_n), .addr_map_i(amap),
    .m_req_i(m_req), .m_add_i(m_add), .m_wen_i(m_wen), .m_wdata_i(m_wdata), .m_be_i(m_be),
    .m_gnt_o(m_gnt), .m_r_valid_o(m_rvld), .m_r_rdata_o(m_rdata), .m_r_opc_o(m_ropc),
    .s_req_o(s_req), .s_add_o(s_add), .s_wen_o(s_wen), .s_wdata_o(s_wdata), .s_be_o(s_be),
    .s_gnt_i(s_gnt), .s_r_valid_i(s_rvld), .s_r_rdata_i(s_rdata), .s_r_opc_i(s_ropc)
  );

  soc_tcdm_xbar #(.NR_MASTERS(NM), .NR_SLAVES(NS), .NR_RULES(3), .DEFAULT_EN(1'b1), .DEFAULT_IDX(1)) dut_dflt (
    .clk_i(clk), .rst_ni(rst_n), .addr_map_i(amap),
    .m_req_i(m_req), .m_add_i(m_add), .m_wen_i(m_wen), .m_wdata_i(m_wdata), .m_be_i(m_be),
    .m_gnt_o(b_m_gnt), .m_r_valid_o(b_m_rvld), .m_r_rdata_o(b_m_rdata), .m_r_opc_o(b_m_ropc),
    .s_req_o(b_s_req), .s_add_o(b_s_add), .s_wen_o(b_s_wen), .s_wdata_o(b_s_wdata), .s_be_o(b_s_be),
    .s_gnt_i(s_gnt), .s_r_valid_i(s_rvld), .s_r_rdata_i(s_rdata), .s_r_opc_i(s_ropc)
  );

  int n_run  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic clr();
    m_req   = '0;
    m_wen   = '0;
    m_add   = '0;
    m_wdata = '0;
    m_be    = '0;
    s_rvld  = '0;
    s_ropc  = '0;
    s_rdata = '0;
  endtask

  task automatic setm(input int i, input logic [31:0] a, input logic w,
                      input logic [31:0] d, input logic [3:0] be);
    m_req[i]          = 1'b1;
    m_add[i*AW +: AW] = a;
    m_wen[i]          = w;
    m_wdata[i*DW +: DW] = d;
    m_be[i*4 +: 4]    = be;
    $display("[TB] txn master %0d %s addr %08h wdata %08h be %h", i, w ? "RD" : "WR", a, d, be);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    amap[0] = '{idx: 32'd0, start_addr: 32'h1C00_0000, end_addr: 32'h1C01_0000};
    amap[1] = '{idx: 32'd1, start_addr: 32'h1C01_0000, end_addr: 32'h1C08_0000};
    amap[2] = '{idx: 32'd2, start_addr: 32'h1A00_0000, end_addr: 32'h1A10_0000};
    clr();
    s_gnt = '1;
    rst_n = 1'b0;
    step();
    step();
    #1;
    chk("rst_rvalid", 64'(m_rvld), 64'h0);
    chk("rst_opc",    64'(m_ropc), 64'h0);
    chk("rst_rdata",  64'(m_rdata[5*DW +: DW]), 64'h0);
    chk("rst_sreq",   64'(s_req), 64'h0);
    chk("rst_gnt",    64'(m_gnt), 64'h0);
    rst_n = 1'b1;
    step();

    // single read to slave 2
    clr();
    setm(0, 32'h1A00_0004, 1'b1, 32'h0, 4'hF);
    #1;
    chk("rd_gnt",  64'(m_gnt), 64'h001);
    chk("rd_sreq", 64'(s_req), 64'h4);
    chk("rd_sadd", 64'(s_add[2*AW +: AW]), 64'h1A00_0004);
    step();
    clr();
    s_rvld = 3'b100;
    s_rdata[2*DW +: DW] = 32'h1234_5678;
    #1;
    chk("rd_rvalid", 64'(m_rvld), 64'h001);
    chk("rd_rdata",  64'(m_rdata[0 +: DW]), 64'h1234_5678);
    chk("rd_opc",    64'(m_ropc), 64'h0);
    step();

    // masters 1 and 3 contend for slave 0
    clr();
    setm(1, 32'h1C00_0010, 1'b1, 32'h0, 4'hF);
    setm(3, 32'h1C00_0014, 1'b1, 32'h0, 4'hF);
    for (int c = 0; c < 6; c++) begin
      #1;
      chk($sformatf("rr_gnt%0d", c), 64'(m_gnt), (c % 2 == 0) ? 64'h002 : 64'h008);
      step();
    end

    // unmapped read -> error responder; default instance forwards to slave 1
    clr();
    setm(5, 32'h0000_0000, 1'b1, 32'h0, 4'hF);
    #1;
    chk("err_gnt",    64'(m_gnt), 64'h020);
    chk("err_nosreq", 64'(s_req), 64'h0);
    chk("dflt_rdreq", 64'(b_s_req), 64'h2);
    step();
    clr();
    #1;
    chk("err_rvalid", 64'(m_rvld), 64'h020);
    chk("err_opc",    64'(m_ropc), 64'h020);
    chk("err_rdata",  64'(m_rdata[5*DW +: DW]), 64'hBADA_CCE5);

    // unmapped write
    setm(5, 32'h0000_0100, 1'b0, 32'hCAFE_F00D, 4'hA);
    #1;
    chk("errw_gnt",    64'(m_gnt), 64'h020);
    chk("errw_nosreq", 64'(s_req), 64'h0);
    chk("dflt_sreq",   64'(b_s_req), 64'h2);
    chk("dflt_wdata",  64'(b_s_wdata[1*DW +: DW]), 64'hCAFE_F00D);
    chk("dflt_be",     64'(b_s_be[4 +: 4]), 64'hA);
    chk("dflt_wen",    64'(b_s_wen[1]), 64'h0);
    step();
    clr();
    #1;
    chk("errw_rvalid", 64'(m_rvld), 64'h020);
    chk("errw_opc",    64'(m_ropc), 64'h020);
    chk("errw_rdata",  64'(m_rdata[5*DW +: DW]), 64'h0);

    // parallel accesses to different slaves
    setm(0, 32'h1C00_0020, 1'b1, 32'h0, 4'hF);
    setm(2, 32'h1C01_0000, 1'b1, 32'h0, 4'hF);
    #1;
    chk("par_gnt",  64'(m_gnt), 64'h005);
    chk("par_sreq", 64'(s_req), 64'h3);
    step();
    clr();
    s_rvld = 3'b011;
    s_rdata[0 +: DW]  = 32'hAAAA_0000;
    s_rdata[DW +: DW] = 32'hBBBB_1111;
    #1;
    chk("par_rvalid", 64'(m_rvld), 64'h005);
    chk("par_rdata0", 64'(m_rdata[0 +: DW]), 64'hAAAA_0000);
    chk("par_rdata2", 64'(m_rdata[2*DW +: DW]), 64'hBBBB_1111);
    step();

    // slave 0 stalls: no grant, pointer must hold at 1
    clr();
    s_gnt = 3'b110;
    setm(4, 32'h1C00_0030, 1'b1, 32'h0, 4'hF);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("stall_gnt%0d", c), 64'(m_gnt), 64'h0);
      chk($sformatf("stall_sreq%0d", c), 64'(s_req), 64'h1);
      step();
    end
    setm(0, 32'h1C00_0040, 1'b1, 32'h0, 4'hF);
    s_gnt = '1;
    #1;
    chk("stall_ptr", 64'(m_gnt), 64'h010);
    step();

    // reset while master 4's response is pending
    clr();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    s_rvld = 3'b001;
    s_rdata[0 +: DW] = 32'hDEAD_BEEF;
    #1;
    chk("rstmid_rvalid", 64'(m_rvld), 64'h0);
    chk("rstmid_rdata",  64'(m_rdata[4*DW +: DW]), 64'h0);
    s_rvld = '0;
    setm(0, 32'h1C00_0050, 1'b1, 32'h0, 4'hF);
    setm(4, 32'h1C00_0054, 1'b1, 32'h0, 4'hF);
    #1;
    chk("rstmid_ptr", 64'(m_gnt), 64'h001);
    step();
    clr();
    step();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
